pc_next_unit: RTL

Program-counter register and next-PC sequencer for the single-cycle MIPS core. It consumes the sign-extended, word-shifted branch offset produced by the immediate extender. It also accepts jump and jump-register requests from decode. It holds the fetch address and selects the following one every cycle, with an optional branch-delay-slot mode.

---
 rtl/pc_pkg.sv | 25 ++
 rtl/pc_target_sel.sv | 43 ++++
 rtl/pc_next_unit.sv | 115 +++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared constants and encodings for the program-counter sequencer.
package pc_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } pc_state_e;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } pc_sel_e;

  // J/JAL keep the 256 MB region of the delay-slot address.
  function automatic logic [31:0] jump_addr(input logic [31:0] base,
                                            input logic [25:0] index);
    return {base[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/pc_target_sel.sv
// Priority arbitration of redirect requests (jr > jump > branch) and target computation.
module pc_target_sel
  import pc_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [31:0] branch_off,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic [31:0] target,
  output logic [1:0]  sel,
  output logic        jr_misaligned
);

  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] jr_target;

  assign br_target = pc_plus4 + branch_off;
  assign j_target  = jump_addr(pc_plus4, jump_target);
  // Low bits are forced to zero so fetch stays word-aligned even on a bad jr.
  assign jr_target = {jr_addr[31:2], 2'b00};

  always_comb begin
    target        = pc_plus4;
    sel           = SEL_SEQ;
    jr_misaligned = 1'b0;
    if (jr) begin
      target        = jr_target;
      sel           = SEL_JR;
      jr_misaligned = (jr_addr[1:0] != 2'b00);
    end else if (jump) begin
      target = j_target;
      sel    = SEL_J;
    end else if (branch_taken) begin
      target = br_target;
      sel    = SEL_BR;
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// PC register and next-PC sequencer. Define BRANCH_DELAY_SLOT_EN for two-cycle
// delay-slot redirects through the PENDING state; otherwise redirects are immediate.
module pc_next_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_off,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        redirect,
  output logic        pending,
  output logic        addr_err
);

  // Request protocol: branch_taken/jump/jr are single-cycle valids with no
  // ready; stall acts as the inverse of ready, and a request seen while stall
  // is high is dropped (the requester re-presents it).

  logic [31:0] pc_q;
  logic        redirect_q;
  logic        addr_err_q;
  logic [31:0] target;
  logic [1:0]  sel;
  logic        jr_misaligned;
  logic        take;

  assign pc_plus4 = pc_q + PC_STEP;
  assign take     = (sel != SEL_SEQ);

  pc_target_sel u_target_sel (
    .pc_plus4      (pc_plus4),
    .branch_taken  (branch_taken),
    .branch_off    (branch_off),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_addr       (jr_addr),
    .target        (target),
    .sel           (sel),
    .jr_misaligned (jr_misaligned)
  );

`ifdef BRANCH_DELAY_SLOT_EN
  pc_state_e   state_q;
  logic [31:0] target_q;
  logic        target_err_q;
  logic        pending_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      redirect_q   <= 1'b0;
      addr_err_q   <= 1'b0;
      state_q      <= IDLE;
      target_q     <= '0;
      target_err_q <= 1'b0;
      pending_q    <= 1'b0;
    end else if (stall) begin
      redirect_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else if (state_q == PENDING) begin
      // Requests are ignored here: a branch in a delay slot is unsupported.
      pc_q       <= target_q;
      redirect_q <= 1'b1;
      addr_err_q <= target_err_q;
      pending_q  <= 1'b0;
      state_q    <= IDLE;
    end else begin
      pc_q       <= pc_plus4;
      redirect_q <= 1'b0;
      addr_err_q <= 1'b0;
      if (take) begin
        // addr_err is held back so it appears with the redirected pc.
        target_q     <= target;
        target_err_q <= jr_misaligned;
        pending_q    <= 1'b1;
        state_q      <= PENDING;
      end
    end
  end

  assign pending = pending_q;
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else if (stall) begin
      redirect_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      pc_q       <= take ? target : pc_plus4;
      redirect_q <= take;
      addr_err_q <= jr_misaligned;
    end
  end

  assign pending = 1'b0;
`endif

  assign pc       = pc_q;
  assign redirect = redirect_q;
  assign addr_err = addr_err_q;

endmodule
